// File: rtl/seq_signed_mac.sv
// Sequential signed multiply-accumulate unit.
// Operands are converted to magnitudes, multiplied by shift-and-add over
// WIDTH cycles, sign-restored, then loaded into or added to the accumulator.
module seq_signed_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         acc_en,
  input  logic                         acc_clr,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   iter,
  output logic                         out_valid,
  output logic [2*WIDTH-1:0]           product,
  output logic [ACC_WIDTH-1:0]         acc
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [2*WIDTH:0]       shreg_q, shreg_d;
  logic                   sign_q, sign_d;
  logic                   acc_en_q, acc_en_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic                   out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]     product_q, product_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         partial_sum;
  logic [2*WIDTH:0]       step_reg;
  logic [2*WIDTH-1:0]     mag;
  logic signed [2*WIDTH-1:0]   prod_signed;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0]   acc_base;

  // Operand magnitudes and the signed result derived from the shift register
  always_comb begin
    a_mag       = a[WIDTH-1] ? -a : a;
    b_mag       = b[WIDTH-1] ? -b : b;
    partial_sum = {1'b0, mcand_q} + shreg_q[2*WIDTH:WIDTH];
    step_reg    = shreg_q[0] ? {partial_sum, shreg_q[WIDTH-1:0]} : shreg_q;
    mag         = shreg_q[2*WIDTH-1:0];
    prod_signed = sign_q ? -mag : mag;
    prod_ext    = ACC_WIDTH'(prod_signed);
    acc_base    = (acc_en_q && !acc_clr) ? acc_q : '0;
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    shreg_d     = shreg_q;
    sign_d      = sign_q;
    acc_en_d    = acc_en_q;
    iter_d      = iter_q;
    out_valid_d = 1'b0;
    product_d   = product_q;
    acc_d       = acc_clr ? '0 : acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          shreg_d  = {{(WIDTH+1){1'b0}}, b_mag};
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          acc_en_d = acc_en;
          iter_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        shreg_d = {1'b0, step_reg[2*WIDTH:1]};
        iter_d  = iter_q + IW'(1);
        if (iter_q == ITER_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d   = prod_signed;
        acc_d       = acc_base + prod_ext;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      shreg_q     <= '0;
      sign_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      shreg_q     <= shreg_d;
      sign_q      <= sign_d;
      acc_en_q    <= acc_en_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign iter      = iter_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign acc       = acc_q;

endmodule
